// File: rtl/uart_pkg.sv
// Shared constants for the UART FIFO transmitter: state encoding and default sizing.
package uart_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 434;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_fifo_tx_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int CLK_DIV = 434,
  parameter int CNT_W   = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_bit_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_end = (r_cnt == LAST);

  // Wrapping at LAST doubles as the clear-on-entry for back-to-back bit states.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// Read-domain consumer of the UART async FIFO: pops bytes and serializes them LSB-first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); default build is 8N1.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CNT_W   = 16
) (
  input  logic              rclk,
  input  logic              rst,
  input  logic              empty,
  input  logic [DATA_W-1:0] rdata,
  output logic              rinc,
  output logic              txd,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
`ifdef UART_TX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_next;
  logic              r_txd;
  logic              w_txd_next;
  logic              r_busy;
  logic              w_pop;
  logic              w_bit_end;
  logic              w_cnt_clr;
`ifdef UART_TX_PARITY_EN
  logic              r_par;
`endif

  assign w_cnt_clr = (r_state == S_IDLE);

  uart_baud_cnt #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W)
  ) u_baud (
    .i_clk    (rclk),
    .i_rst    (rst),
    .i_clr    (w_cnt_clr),
    .o_bit_end(w_bit_end)
  );

  always_ff @(posedge rclk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    w_pop        = 1'b0;
    w_txd_next   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!empty) begin
          w_pop        = 1'b1;
          w_shift_next = rdata;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_idx == LAST_IDX) begin
            w_idx_next   = '0;
            w_state_next = S_AFTER_DATA;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // txd is registered, so drive it from the state about to be entered.
    case (w_state_next)
      S_START: w_txd_next = 1'b0;
      S_DATA:  w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_next = r_par;
`endif
      default: w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_idx   <= w_idx_next;
      r_txd   <= w_txd_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge rclk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= ^rdata;
    end
  end
`endif

  assign rinc = w_pop & ~rst;
  assign txd  = r_txd;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Scoreboard bench for uart_fifo_tx: a FIFO model feeds the DUT, a line decoder checks frames.
module tb_uart_fifo_tx;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       rinc;
  logic       txd;
  logic       busy;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int n_rinc = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  bit toggle_en = 1'b0;
  bit mask = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_fifo_tx #(
    .DATA_W (8),
    .CLK_DIV(CLK_DIV),
    .CNT_W  (16)
  ) dut (
    .rclk (clk),
    .rst  (rst),
    .empty(empty),
    .rdata(rdata),
    .rinc (rinc),
    .txd  (txd),
    .busy (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // FIFO model: pops when the DUT strobed rinc in the cycle before the edge.
  initial begin : drv
    bit pend;
    forever begin
      @(negedge clk);
      pend = rinc;
      @(posedge clk);
      #1;
      if (pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      mask  = toggle_en ? ~mask : 1'b0;
      empty = (fifo_q.size() == 0) || mask;
      rdata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (rinc) begin
      n_rinc++;
      chk("rinc_legal", int'({empty, busy, rst}), 0);
    end
    if (!rst && !busy && !empty) chk("pop_ready", int'(rinc), 1);
  end

  int brun = 0;
  bit bskip = 1'b0;
  bit bprev = 1'b0;
  always @(negedge clk) begin
    if (rst && busy) bskip = 1'b1;
    if (busy) begin
      brun++;
    end else if (bprev) begin
      if (!bskip) chk("busy_len", brun, NB * CLK_DIV);
      brun  = 0;
      bskip = 1'b0;
    end
    bprev = busy;
  end

  // Line decoder: samples every cycle of every bit, aborts the frame on reset.
  initial begin : mon
    logic [NB-1:0] bits;
    bit ok_shape;
    bit aborted;
    logic [7:0] e;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (!rst && txd == 1'b0) begin
        bits = '0;
        ok_shape = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < NB; b++) begin
          for (int s = 0; s < CLK_DIV; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (rst) aborted = 1'b1;
            else if (s == 0) bits[b] = txd;
            else if (txd != bits[b]) ok_shape = 1'b0;
            if (aborted) break;
          end
          if (aborted) break;
        end
        if (!aborted) begin
          d = bits[8:1];
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", int'(d), -1);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", int'(d), int'(e));
            chk("stop_bit", int'(bits[NB-1]), 1);
            chk("bit_width", int'(ok_shape), 1);
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", int'(bits[9]), int'(^e));
`endif
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit expect_frame);
    fifo_q.push_back(b);
    if (expect_frame) exp_q.push_back(b);
  endtask

  task automatic wait_rinc(output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rinc) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("rinc_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy && !rinc && fifo_q.size() == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(input int ncyc, input string name);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      chk(name, int'({txd, busy, rinc}), 4);
    end
  endtask

  initial begin : stim
    int c1;
    int c2;
    int r0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle(100, "reset_idle");

    // Single byte 0x55
    push(8'h55, 1'b1);
    wait_rinc(c1);
    @(negedge clk);
    chk("rinc_pulse", int'(rinc), 0);
    chk("start_after_pop", int'(txd), 0);
    wait_done();

    // Back-to-back frames
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    wait_rinc(c1);
    wait_rinc(c2);
    chk("b2b_gap", c2 - c1, NB * CLK_DIV + 1);
    wait_done();

    // Reset during DATA bit 3 of 0xF0
    push(8'hF0, 1'b0);
    wait_rinc(c1);
    repeat (18) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_frame_bit3", int'(txd), 0);
    @(negedge clk);
    chk("abort_lines", int'({txd, busy, rinc}), 4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle(40, "idle_after_abort");

    // Parity-sensitive bytes
    push(8'h07, 1'b1);
    push(8'h03, 1'b1);
    wait_done();

    // empty toggling every cycle around the frames
    toggle_en = 1'b1;
    r0 = n_rinc;
    push(8'h96, 1'b1);
    push(8'h69, 1'b1);
    wait_done();
    chk("toggle_pop_count", n_rinc - r0, 2);
    toggle_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

endmodule
